// File: rtl/mspe_pkg.sv
// Shared types and constants for the MSPE source arbiter.
//   arb_state_t : arbiter FSM state (idle/arbitrating vs streaming a payload)
//   MSPE_LEN_W  : default width of the header length field
//   idx_w()     : width of an index into n items (at least 1 bit)
package mspe_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_STREAM
    } arb_state_t;

    localparam int MSPE_LEN_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mspe_src_arbiter_if.sv
// Bundle of the arbiter's channel-side and src-side signals.
//   en_mask/ch_data/ch_count/ch_re : per-channel FIFO heads, fill counts, pops
//   src_data/valid/sop/eop/ready   : streaming output with backpressure
//   src_channel                    : source tag, only when MSPE_SRC_ARB_TAG_EN is defined
// Modports: master = arbiter side, slave = FIFO/sink side.
interface mspe_src_arbiter_if
    import mspe_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 512,
    parameter int CNT_W    = 32
);
    localparam int CH_W = idx_w(CHANNELS);

    logic [CHANNELS-1:0]        en_mask;
    logic [CHANNELS*DATA_W-1:0] ch_data;
    logic [CHANNELS*CNT_W-1:0]  ch_count;
    logic [CHANNELS-1:0]        ch_re;
    logic [DATA_W-1:0]          src_data;
    logic                       src_valid;
    logic                       src_sop;
    logic                       src_eop;
    logic                       src_ready;
`ifdef MSPE_SRC_ARB_TAG_EN
    logic [CH_W-1:0]            src_channel;
`endif

    modport master (
        input  en_mask, ch_data, ch_count, src_ready,
        output ch_re, src_data, src_valid, src_sop, src_eop
`ifdef MSPE_SRC_ARB_TAG_EN
        , output src_channel
`endif
    );

    modport slave (
        output en_mask, ch_data, ch_count, src_ready,
        input  ch_re, src_data, src_valid, src_sop, src_eop
`ifdef MSPE_SRC_ARB_TAG_EN
        , input src_channel
`endif
    );

endinterface

// File: rtl/mspe_rr_pick.sv
// Rotating-priority encoder: returns the first requester after ptr,
// wrapping from N-1 back to 0. Purely combinational.
//   req     : request vector
//   ptr     : last granted index (highest priority goes to ptr+1)
//   gnt_idx : chosen index (valid when gnt_any)
//   gnt_any : at least one request present
module mspe_rr_pick
    import mspe_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        req,
    input  logic [idx_w(N)-1:0] ptr,
    output logic [idx_w(N)-1:0] gnt_idx,
    output logic                gnt_any
);
    localparam int W = idx_w(N);

    always_comb begin
        int j;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // Walk from the farthest candidate to the nearest so the closest
        // requester after ptr is the one left standing.
        for (int i = N; i >= 1; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[W'(j)]) begin
                gnt_idx = W'(j);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mspe_src_arbiter.sv
// Round-robin packet arbiter draining CHANNELS show-ahead source FIFOs onto
// one streaming src port. A FIFO packet is a header beat (payload length in
// bits [LEN_W-1:0]) followed by that many payload beats. The header is popped
// and dropped; only complete packets are granted; src_ready backpressure is
// honoured through a single output register.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mspe_src_arbiter_if.master (FIFO heads/counts/pops, src stream)
// Optional: define MSPE_SRC_ARB_TAG_EN to add bus.src_channel (granted channel,
// registered alongside src_data).
module mspe_src_arbiter
    import mspe_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 512,
    parameter int CNT_W    = 32,
    parameter int LEN_W    = MSPE_LEN_W
) (
    input logic                clk,
    input logic                reset,
    mspe_src_arbiter_if.master bus
);
    localparam int CH_W  = idx_w(CHANNELS);
    // Wide enough that len+1 and the count never wrap when compared.
    localparam int CMP_W = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;

    logic [DATA_W-1:0]   head_beat [CHANNELS];
    logic [LEN_W-1:0]    head_len  [CHANNELS];
    logic [CHANNELS-1:0] eligible;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        assign cnt          = bus.ch_count[c*CNT_W +: CNT_W];
        assign head_beat[c] = bus.ch_data[c*DATA_W +: DATA_W];
        assign head_len[c]  = head_beat[c][LEN_W-1:0];
        // Whole packet (header + payload) must already sit in the FIFO.
        assign eligible[c]  = bus.en_mask[c] && (cnt != '0) &&
                              (CMP_W'(cnt) >= CMP_W'(head_len[c]) + CMP_W'(1));
    end

    arb_state_t       state, state_nxt;
    logic [LEN_W-1:0] remaining, len_latched, sel_len;
    logic [CH_W-1:0]  gnt, ptr, pick_idx;
    logic             pick_any, grant, pop;

    mspe_rr_pick #(.N(CHANNELS)) u_pick (
        .req     (eligible),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign sel_len = head_len[pick_idx];

    // NOTE: every output of this block gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        bus.ch_re  = '0;
        grant      = 1'b0;
        pop        = 1'b0;
        if (!reset) begin
            unique case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        // Header pop; a zero-length packet ends right here.
                        bus.ch_re[pick_idx] = 1'b1;
                        grant               = 1'b1;
                        if (sel_len != '0) state_nxt = ARB_STREAM;
                    end
                end
                ARB_STREAM: begin
                    // Pull a beat whenever the output register is empty or draining.
                    pop = (!bus.src_valid || bus.src_ready) && (remaining != '0);
                    bus.ch_re[gnt] = pop;
                    if (pop && remaining == LEN_W'(1)) state_nxt = ARB_IDLE;
                end
                default: state_nxt = ARB_IDLE;
            endcase
        end
    end

    // NOTE: registered state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ARB_IDLE;
            remaining     <= '0;
            len_latched   <= '0;
            gnt           <= '0;
            ptr           <= CH_W'(CHANNELS - 1);
            bus.src_data  <= '0;
            bus.src_valid <= 1'b0;
            bus.src_sop   <= 1'b0;
            bus.src_eop   <= 1'b0;
`ifdef MSPE_SRC_ARB_TAG_EN
            bus.src_channel <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (grant) begin
                gnt         <= pick_idx;
                ptr         <= pick_idx;
                remaining   <= sel_len;
                len_latched <= sel_len;
            end else if (pop) begin
                remaining <= remaining - LEN_W'(1);
            end

            if (pop) begin
                bus.src_data  <= head_beat[gnt];
                bus.src_valid <= 1'b1;
                bus.src_sop   <= (remaining == len_latched);
                bus.src_eop   <= (remaining == LEN_W'(1));
`ifdef MSPE_SRC_ARB_TAG_EN
                bus.src_channel <= gnt;
`endif
            end else if (bus.src_ready) begin
                bus.src_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mspe_src_arbiter.sv
// Self-checking bench for mspe_src_arbiter: FIFOs are modelled as queues, a
// packet-level round-robin model predicts the output beat sequence into a
// scoreboard, and a negedge monitor compares every accepted beat.
module tb_mspe_src_arbiter;
    import mspe_pkg::*;

    localparam int CHANNELS = 4;
    localparam int DATA_W   = 64;
    localparam int CNT_W    = 8;
    localparam int LEN_W    = MSPE_LEN_W;
    localparam int CH_W     = idx_w(CHANNELS);

    typedef logic [DATA_W-1:0] beat_t;
    typedef struct packed {
        beat_t           data;
        logic            sop;
        logic            eop;
        logic [CH_W-1:0] ch;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mspe_src_arbiter_if #(.CHANNELS(CHANNELS), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    mspe_src_arbiter #(
        .CHANNELS (CHANNELS),
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W),
        .LEN_W    (LEN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    errors = 0;
    int    checks = 0;
    beat_t fifo_q [CHANNELS][$];
    int    m_len  [CHANNELS][$];
    beat_t m_beat [CHANNELS][$];
    int    m_ptr;
    exp_t  sb [$];
    int    cyc = 0;
    int    re_cnt [CHANNELS];
    bit    re_seen, valid_seen, rand_ready;
    int    first_re_cyc, first_valid_cyc, eop_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t rnd_beat();
        return {$urandom, $urandom};
    endfunction

    task automatic refresh();
        for (int c = 0; c < CHANNELS; c++) begin
            bus.ch_data[c*DATA_W +: DATA_W] = (fifo_q[c].size() != 0) ? fifo_q[c][0] : '0;
            bus.ch_count[c*CNT_W +: CNT_W]  = CNT_W'(fifo_q[c].size());
        end
    endtask

    // Complete packet into FIFO c and into the reference model.
    task automatic push_pkt(input int c, input int len);
        beat_t b;
        b = rnd_beat();
        b[LEN_W-1:0] = LEN_W'(len);
        fifo_q[c].push_back(b);
        m_len[c].push_back(len);
        for (int k = 0; k < len; k++) begin
            b = rnd_beat();
            fifo_q[c].push_back(b);
            m_beat[c].push_back(b);
        end
        refresh();
    endtask

    // Reference: with all pending packets complete, grants follow plain
    // round-robin over enabled non-empty channels starting after m_ptr.
    task automatic issue(input logic [CHANNELS-1:0] mask);
        int   c, c2, len;
        bit   found;
        exp_t e;
        do begin
            found = 0;
            c = 0;
            for (int i = 1; i <= CHANNELS; i++) begin
                c2 = (m_ptr + i) % CHANNELS;
                if (!found && mask[c2] && m_len[c2].size() != 0) begin
                    found = 1;
                    c = c2;
                end
            end
            if (found) begin
                m_ptr = c;
                len = m_len[c].pop_front();
                for (int k = 0; k < len; k++) begin
                    e.data = m_beat[c].pop_front();
                    e.sop  = (k == 0);
                    e.eop  = (k == len - 1);
                    e.ch   = CH_W'(c);
                    sb.push_back(e);
                end
            end
        end while (found);
        bus.en_mask = mask;
    endtask

    // One clock: snapshot pops after the monitor ran, apply them just after the edge.
    task automatic tick();
        logic [CHANNELS-1:0] re_snap;
        @(negedge clk);
        #1;
        re_snap = bus.ch_re;
        if (!reset && re_snap != '0) begin
            re_seen = 1;
            if (first_re_cyc < 0) first_re_cyc = cyc;
            check("ch_re_onehot", 64'($countones(re_snap) <= 1), 64'd1);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (re_snap[c]) begin
                re_cnt[c]++;
                check("pop_nonempty", 64'(fifo_q[c].size() != 0), 64'd1);
                if (fifo_q[c].size() != 0) void'(fifo_q[c].pop_front());
            end
        end
        if (rand_ready) bus.src_ready = ($urandom_range(0, 3) != 0);
        refresh();
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && !bus.src_valid) break;
            tick();
        end
        check("drain_done", 64'(sb.size()), 64'd0);
        repeat (12) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.en_mask = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            fifo_q[c].delete();
            m_len[c].delete();
            m_beat[c].delete();
        end
        sb.delete();
        m_ptr = CHANNELS - 1;
        refresh();
        repeat (2) tick();
        check("rst_valid", 64'(bus.src_valid), 64'd0);
        check("rst_sop",   64'(bus.src_sop),   64'd0);
        check("rst_eop",   64'(bus.src_eop),   64'd0);
        check("rst_data",  64'(bus.src_data),  64'd0);
        check("rst_ch_re", 64'(bus.ch_re),     64'd0);
`ifdef MSPE_SRC_ARB_TAG_EN
        check("rst_channel", 64'(bus.src_channel), 64'd0);
`endif
        reset = 1'b0;
    endtask

    // Monitor: compare each accepted beat and hold-stability under backpressure.
    logic stalled = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(bus.src_valid), 64'd1);
                check("stall_data",  64'(bus.src_data),  64'(held.data));
                check("stall_sopeop", 64'({bus.src_sop, bus.src_eop}), 64'({held.sop, held.eop}));
            end
            if (bus.src_valid) begin
                valid_seen = 1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (bus.src_valid && bus.src_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", bus.src_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", 64'(bus.src_data), 64'(e.data));
                    check("beat_sop",  64'(bus.src_sop),  64'(e.sop));
                    check("beat_eop",  64'(bus.src_eop),  64'(e.eop));
`ifdef MSPE_SRC_ARB_TAG_EN
                    check("beat_channel", 64'(bus.src_channel), 64'(e.ch));
`endif
                    if (bus.src_eop) eop_cyc = cyc;
                end
            end
            stalled   = bus.src_valid && !bus.src_ready;
            held.data = bus.src_data;
            held.sop  = bus.src_sop;
            held.eop  = bus.src_eop;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        beat_t       b;
        beat_t       part [4];
        logic [5:0]  pat;
        int          n;

        bus.src_ready = 1'b1;
        bus.en_mask   = '0;
        rand_ready    = 0;
        for (int c = 0; c < CHANNELS; c++) re_cnt[c] = 0;
        do_reset();

        // 1: single 3-beat packet on ch1, back-to-back, latency T+2.
        push_pkt(1, 3);
        first_re_cyc = -1;
        first_valid_cyc = -1;
        issue(4'b0010);
        drain();
        check("t1_re_count", 64'(re_cnt[1]), 64'd4);
        check("t1_latency", 64'(first_valid_cyc - first_re_cyc), 64'd2);
        check("t1_back_to_back", 64'(eop_cyc - first_valid_cyc), 64'd2);

        // 2a: ptr left at 1, so ch2 goes before ch0.
        bus.en_mask = '0;
        push_pkt(0, 2);
        push_pkt(2, 2);
        issue(4'b0101);
        drain();
        // 2b: from reset ch0 goes first.
        do_reset();
        push_pkt(0, 2);
        push_pkt(2, 2);
        issue(4'b0101);
        drain();

        // 3: incomplete packet on ch3 is never granted until all beats arrive.
        bus.en_mask = '0;
        part[0] = rnd_beat();
        part[0][LEN_W-1:0] = LEN_W'(4);
        for (int k = 1; k < 4; k++) part[k] = rnd_beat();
        fifo_q[3].push_back(part[0]);
        b = rnd_beat();
        fifo_q[3].push_back(b);
        refresh();
        bus.en_mask = 4'b1000;
        re_seen = 0;
        valid_seen = 0;
        repeat (10) tick();
        check("t3_no_pop", 64'(re_seen), 64'd0);
        check("t3_no_valid", 64'(valid_seen), 64'd0);
        bus.en_mask = '0;
        for (int k = 1; k < 4; k++) fifo_q[3].push_back(part[k]);
        refresh();
        m_len[3].push_back(4);
        m_beat[3].push_back(b);
        for (int k = 1; k < 4; k++) m_beat[3].push_back(part[k]);
        issue(4'b1000);
        drain();

        // 4: backpressure pattern during a 4-beat packet.
        bus.en_mask = '0;
        push_pkt(1, 4);
        issue(4'b0010);
        for (int i = 0; i < 20; i++) begin
            if (bus.src_valid) break;
            tick();
        end
        pat = 6'b101001;
        for (int k = 0; k < 6; k++) begin
            bus.src_ready = pat[k];
            tick();
        end
        bus.src_ready = 1'b1;
        drain();

        // 5: zero-length header is dropped, then a 1-beat packet.
        bus.en_mask = '0;
        push_pkt(2, 0);
        push_pkt(2, 1);
        issue(4'b0100);
        drain();

        // 6a: len=255 header can never fit an 8-bit count; must stay blocked.
        bus.en_mask = '0;
        b = rnd_beat();
        b[LEN_W-1:0] = LEN_W'(255);
        fifo_q[2].push_back(b);
        for (int k = 0; k < 10; k++) fifo_q[2].push_back(rnd_beat());
        refresh();
        bus.en_mask = 4'b0100;
        re_seen = 0;
        repeat (8) tick();
        check("t6_long_hdr_blocked", 64'(re_seen), 64'd0);
        // 6b: reset mid-packet under backpressure.
        bus.src_ready = 1'b0;
        push_pkt(0, 4);
        issue(4'b0101);
        for (int i = 0; i < 20; i++) begin
            if (bus.src_valid) break;
            tick();
        end
        tick();
        do_reset();
        bus.src_ready = 1'b1;
        // 6c: masked channel is never granted.
        push_pkt(0, 2);
        re_seen = 0;
        valid_seen = 0;
        repeat (10) tick();
        check("t6_masked_no_pop", 64'(re_seen), 64'd0);
        check("t6_masked_no_valid", 64'(valid_seen), 64'd0);
        issue(4'b0001);
        drain();

        // Randomized bursts with random masks and backpressure.
        rand_ready = 1;
        for (int burst = 0; burst < 40; burst++) begin
            bus.en_mask = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                n = $urandom_range(0, 2);
                for (int p = 0; p < n; p++) push_pkt(c, $urandom_range(0, 5));
            end
            issue(CHANNELS'($urandom_range(1, 15)));
            drain();
        end
        rand_ready = 0;
        bus.src_ready = 1'b1;
        issue(4'b1111);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
